// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES block constants, block type and byte-slot indexing helper
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_BYTES = 16;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;

  // Bit position of the top bit of byte slot idx; slot 0 sits in [127:120].
  // Used as blk[aes_byte_lsb(idx) -: 8].
  function automatic int aes_byte_lsb(input int idx);
    return 127 - 8 * idx;
  endfunction

endpackage

// File: rtl/aes_byte_packer.sv
// rtl/aes_byte_packer.sv - packs a byte stream into 128-bit AES blocks with a one-block output holding register
module aes_byte_packer
  import aes_pkg::*;
#(
  parameter int          BLK_BYTES = 16,
  parameter logic [7:0]  PAD_BYTE  = 8'h00
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_blk,
  output logic         out_last,
  output logic [4:0]   out_nbytes,
  output logic         ovf_err
);

  localparam logic [3:0] LAST_SLOT = 4'(BLK_BYTES - 1);

  logic [3:0] acc_cnt;
  aes_blk_t   acc;
  aes_blk_t   blk_next;
  logic       stall_q;
  logic       out_blocked;
  logic       in_xfer;
  logic       completing;
  logic       out_xfer;

  // A completing byte may only enter when the output register is free or draining this cycle.
  assign out_blocked = out_valid && !out_ready;
  assign in_ready    = !(out_blocked && (acc_cnt == LAST_SLOT || in_last));
  assign in_xfer     = in_valid && in_ready;
  assign completing  = in_xfer && (acc_cnt == LAST_SLOT || in_last);
  assign out_xfer    = out_valid && out_ready;

  // Accumulator with the incoming byte merged in and all later slots padded.
  always_comb begin
    blk_next = acc;
    for (int i = 0; i < AES_BYTES; i++) begin
      if (4'(i) == acc_cnt) begin
        blk_next[aes_byte_lsb(i) -: 8] = in_byte;
      end else if (4'(i) > acc_cnt) begin
        blk_next[aes_byte_lsb(i) -: 8] = PAD_BYTE;
      end
    end
  end

  // Accumulation, block hand-off to the holding register, and the sticky protocol checker.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_cnt    <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_blk    <= '0;
      out_last   <= 1'b0;
      out_nbytes <= '0;
      ovf_err    <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      if (completing) begin
        out_blk    <= blk_next;
        out_last   <= in_last;
        out_nbytes <= 5'(acc_cnt) + 5'd1;
        out_valid  <= 1'b1;
        acc_cnt    <= '0;
        acc        <= '0;
      end else begin
        if (in_xfer) begin
          acc     <= blk_next;
          acc_cnt <= acc_cnt + 4'd1;
        end
        if (out_xfer) begin
          out_valid <= 1'b0;
        end
      end
      stall_q <= in_valid && !in_ready;
      if (stall_q && !in_valid) begin
        ovf_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_byte_packer.sv
// tb/tb_aes_byte_packer.sv - randomized and directed self-checking bench for aes_byte_packer
module tb_aes_byte_packer;

  typedef struct {
    logic [127:0] blk;
    logic [4:0]   nbytes;
    logic         last;
  } blk_rec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_byte;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_blk;
  logic         out_last;
  logic [4:0]   out_nbytes;
  logic         ovf_err;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] cur[$];
  blk_rec_t   exp_q[$];
  logic       m_ovf;
  logic       m_stall_prev;

  aes_byte_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_byte    (in_byte),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_blk    (out_blk),
    .out_last   (out_last),
    .out_nbytes (out_nbytes),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic blk_rec_t make_block(input logic lst);
    blk_rec_t r;
    r.blk = '0;
    for (int i = 0; i < 16; i++) begin
      r.blk = {r.blk[119:0], (i < cur.size()) ? cur[i] : 8'h00};
    end
    r.nbytes = 5'(cur.size());
    r.last   = lst;
    return r;
  endfunction

  // One clock cycle: drive, check the DUT against the model, then advance the model over the edge.
  task automatic step(input logic v, input logic [7:0] b, input logic l, input logic ordy,
                      output logic accepted);
    logic full;
    logic exp_rdy;
    @(negedge clk);
    in_valid  = v;
    in_byte   = b;
    in_last   = l;
    out_ready = ordy;
    #1;
    full = (exp_q.size() > 0);
    chk("out_valid", 128'(out_valid), 128'(full));
    if (full) begin
      chk("out_blk", out_blk, exp_q[0].blk);
      chk("out_nbytes", 128'(out_nbytes), 128'(exp_q[0].nbytes));
      chk("out_last", 128'(out_last), 128'(exp_q[0].last));
    end
    exp_rdy = !(full && !ordy && (cur.size() == 15 || l));
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    chk("ovf_err", 128'(ovf_err), 128'(m_ovf));
    accepted = v && exp_rdy;
    if (full && ordy) void'(exp_q.pop_front());
    if (accepted) begin
      cur.push_back(b);
      if (cur.size() == 16 || l) begin
        exp_q.push_back(make_block(l));
        cur.delete();
      end
    end
    if (m_stall_prev && !v) m_ovf = 1'b1;
    m_stall_prev = v && !exp_rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_byte  = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cur.delete();
    exp_q.delete();
    m_ovf        = 1'b0;
    m_stall_prev = 1'b0;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_blk", out_blk, 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    chk("rst_out_nbytes", 128'(out_nbytes), 128'(0));
    chk("rst_ovf_err", 128'(ovf_err), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic acc;
    logic pend_v;
    logic [7:0] pend_b;
    logic pend_l;
    int vcnt;
    rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    m_ovf = 1'b0; m_stall_prev = 1'b0;
    do_reset();

    // 16 bytes 00..0F back to back, output always ready
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, 1'b1, acc);
    chk("t1_blk", out_blk, 128'h000102030405060708090A0B0C0D0E0F);
    chk("t1_nbytes", 128'(out_nbytes), 128'(16));
    chk("t1_valid", 128'(out_valid), 128'(1));
    step(1'b0, 8'h00, 1'b0, 1'b1, acc);
    chk("t1_valid_1cyc", 128'(out_valid), 128'(0));

    // short final block
    step(1'b1, 8'hAA, 1'b0, 1'b1, acc);
    step(1'b1, 8'hBB, 1'b0, 1'b1, acc);
    step(1'b1, 8'hCC, 1'b1, 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    chk("t2_blk", out_blk, 128'hAABBCC00_00000000_00000000_00000000);
    chk("t2_nbytes", 128'(out_nbytes), 128'(3));
    chk("t2_last", 128'(out_last), 128'(1));
    step(1'b0, 8'h00, 1'b0, 1'b1, acc);

    // 32 bytes with output stalled: last byte of second block must wait
    for (int i = 0; i < 31; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, acc);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'h5F, 1'b0, 1'b0, acc);
      chk("t3_stalled", 128'(acc), 128'(0));
    end
    step(1'b1, 8'h5F, 1'b0, 1'b1, acc);
    chk("t3_release", 128'(acc), 128'(1));
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    chk("t3_no_bubble", 128'(out_valid), 128'(1));
    chk("t3_blk2", out_blk, 128'h505152535455565758595A5B5C5D5E5F);
    step(1'b0, 8'h00, 1'b0, 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, 1'b1, acc);

    // reset mid-block, then a clean 16-byte block
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b1, acc);
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    chk("t5_blk", out_blk, 128'h101112131415161718191A1B1C1D1E1F);

    // drop in_valid while stalled -> sticky ovf_err
    step(1'b1, 8'h77, 1'b1, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    chk("t6_ovf_set", 128'(ovf_err), 128'(1));
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b0, 1'b1, acc);
    chk("t6_ovf_sticky", 128'(ovf_err), 128'(1));
    do_reset();

    // randomized traffic; the source holds a stalled byte until it is taken
    pend_v = 1'b0; pend_b = 8'h00; pend_l = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend_v && ($urandom_range(0, 3) != 0)) begin
        pend_v = 1'b1;
        pend_b = 8'($urandom);
        pend_l = ($urandom_range(0, 11) == 0);
      end
      step(pend_v, pend_b, pend_l, 1'($urandom_range(0, 2) != 0), acc);
      if (acc) pend_v = 1'b0;
    end
    vcnt = 0;
    while (exp_q.size() > 0 && vcnt < 8) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, acc);
      vcnt++;
    end
    chk("drain_done", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
